// File: rtl/usb_utmi_pkg.sv
// Shared types for the UTMI SYNC detector.
//   sync_state_e : detector FSM states
//   sym_e        : decoded line symbol for one sample strobe
//   ERR_*        : err_code values reported with S_err
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ALT   = 2'd2,
    ST_DONE  = 2'd3
  } sync_state_e;

  typedef enum logic [2:0] {
    SYM_NONE = 3'd0,
    SYM_J    = 3'd1,
    SYM_K    = 3'd2,
    SYM_SE0  = 3'd3,
    SYM_INV  = 3'd4
  } sym_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_PATTERN = 2'd0;
  localparam err_code_t ERR_SE0     = 2'd1;
  localparam err_code_t ERR_LENGTH  = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  // Line qualifier priority: SE0 over J&K (invalid) over K over J.
  function automatic sym_e decode_sym(input logic se0, input logic j, input logic k);
    if (se0)          return SYM_SE0;
    else if (j && k)  return SYM_INV;
    else if (k)       return SYM_K;
    else if (j)       return SYM_J;
    else              return SYM_NONE;
  endfunction

endpackage

// File: rtl/sync_detector_param_if.sv
// Bus between a line sampler (master) and the SYNC detector (slave).
//   S_en/hs_mode/sample/J/K/SE0 : master -> detector controls and line qualifiers
//   S_det/S_err/err_code        : detector result pulses and cause
//   sym_cnt/busy                : detector progress/status
interface sync_detector_param_if #(
  parameter int unsigned CW = 6
);

  logic          S_en;
  logic          hs_mode;
  logic          sample;
  logic          J;
  logic          K;
  logic          SE0;
  logic          S_det;
  logic          S_err;
  logic [1:0]    err_code;
  logic [CW-1:0] sym_cnt;
  logic          busy;

  modport master (
    output S_en, hs_mode, sample, J, K, SE0,
    input  S_det, S_err, err_code, sym_cnt, busy
  );

  modport slave (
    input  S_en, hs_mode, sample, J, K, SE0,
    output S_det, S_err, err_code, sym_cnt, busy
  );

endinterface

// File: rtl/sync_detector_param.sv
// USB SYNC pattern detector (FS fixed length, HS variable length).
//   CLK, RST : clock, asynchronous active-low reset
//   bus      : slave side of sync_detector_param_if
//              in : S_en, hs_mode, sample, J, K, SE0
//              out: S_det, S_err, err_code, sym_cnt, busy (all registered)
module sync_detector_param
  import usb_utmi_pkg::*;
#(
  parameter int unsigned FS_LEN = 8,
  parameter int unsigned HS_LEN = 32,
  parameter int unsigned HS_MIN = 12,
  parameter int unsigned TMO    = 64,
  parameter int unsigned CW     = $clog2(HS_LEN + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  sync_detector_param_if.slave  bus
);

  localparam int unsigned TW = $clog2(TMO + 1);

  sync_state_e   state_q, state_d;
  logic          hs_q, hs_d;
  logic          exp_k_q, exp_k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  err_code_t     code_q, code_d;
  logic          det_q, det_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  sym_e          sym;
  logic [CW-1:0] len;
  logic [CW-1:0] max_len;
  logic          len_ok;
  logic          fail;
  logic          stay;
  err_code_t     fail_code;

  assign sym     = decode_sym(bus.SE0, bus.J, bus.K);
  // Candidate length if the current symbol is accepted; only used while cnt_q < max_len.
  assign len     = cnt_q + CW'(1);
  assign max_len = hs_q ? CW'(HS_LEN) : CW'(FS_LEN);
  assign len_ok  = hs_q ? ((len >= CW'(HS_MIN)) && (len <= CW'(HS_LEN)))
                        : (len == CW'(FS_LEN));

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      hs_q    <= 1'b0;
      exp_k_q <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      code_q  <= ERR_PATTERN;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_d;
      exp_k_q <= exp_k_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      det_q   <= det_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    hs_d      = hs_q;
    exp_k_d   = exp_k_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    code_d    = code_q;
    det_d     = 1'b0;
    fail      = 1'b0;
    stay      = 1'b0;
    fail_code = ERR_PATTERN;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.S_en) begin
          state_d = ST_ARMED;
          hs_d    = bus.hs_mode;
          cnt_d   = '0;
          tmo_d   = '0;
          code_d  = ERR_PATTERN;
        end
      end

      ST_ARMED: begin
        if (!bus.S_en) begin
          state_d = ST_IDLE;
        end else if (bus.sample) begin
          case (sym)
            SYM_SE0: begin
              fail      = 1'b1;
              fail_code = ERR_SE0;
            end
            SYM_INV: fail = 1'b1;
            SYM_K: begin
              state_d = ST_ALT;
              cnt_d   = CW'(1);
              exp_k_d = 1'b0;
            end
            // HS hubs may strip leading bits, so a J before the first K is tolerated.
            SYM_J: begin
              if (!hs_q) fail = 1'b1;
              else       stay = 1'b1;
            end
            default: stay = 1'b1;
          endcase
          // Every strobe that keeps us waiting for the first K consumes timeout budget.
          if (stay) begin
            if (tmo_q == TW'(TMO - 1)) begin
              fail      = 1'b1;
              fail_code = ERR_TIMEOUT;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
        end
      end

      ST_ALT: begin
        if (!bus.S_en) begin
          state_d = ST_IDLE;
        end else if (bus.sample) begin
          case (sym)
            SYM_SE0: begin
              fail      = 1'b1;
              fail_code = ERR_SE0;
            end
            SYM_INV: fail = 1'b1;
            SYM_J, SYM_K: begin
              if (cnt_q >= max_len) begin
                // Already at the mode maximum: any further symbol overruns it.
                fail      = 1'b1;
                fail_code = ERR_LENGTH;
              end else if ((sym == SYM_K) == exp_k_q) begin
                cnt_d   = len;
                exp_k_d = ~exp_k_q;
              end else if (sym == SYM_K) begin
                // KK terminates the SYNC; the closing K counts toward its length.
                cnt_d = len;
                if (len_ok) begin
                  det_d   = 1'b1;
                  state_d = ST_DONE;
                end else begin
                  fail      = 1'b1;
                  fail_code = ERR_LENGTH;
                end
              end else begin
                fail = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      ST_DONE: begin
        if (!bus.S_en) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      state_d = ST_DONE;
      code_d  = fail_code;
    end
    err_d  = fail;
    busy_d = (state_d == ST_ARMED) || (state_d == ST_ALT);
  end

  assign bus.S_det    = det_q;
  assign bus.S_err    = err_q;
  assign bus.err_code = code_q;
  assign bus.sym_cnt  = cnt_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sync_detector_param.sv
// Self-checking bench for sync_detector_param: directed table, hand-written
// corner sequences, and randomized SYNC-like streams against a sequence model.
module tb_sync_detector_param;

  localparam int FS_LEN = 8;
  localparam int HS_LEN = 32;
  localparam int HS_MIN = 12;
  localparam int TMO    = 64;
  localparam int CW     = 6;

  logic CLK = 1'b0;
  logic RST;

  sync_detector_param_if #(.CW(CW)) bus();

  sync_detector_param #(
    .FS_LEN(FS_LEN), .HS_LEN(HS_LEN), .HS_MIN(HS_MIN), .TMO(TMO), .CW(CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  // kind: 0 = no decision, 1 = S_det, 2 = S_err
  typedef struct {
    bit    hs;
    string pat;
    int    kind;
    int    code;
    int    cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit hs, input string pat, input int kind, input int code, input int cnt);
    vec_t v;
    v.hs = hs; v.pat = pat; v.kind = kind; v.code = code; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  function automatic string alt(input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, "KJ"};
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Non-sample cycle; qualifiers are randomized since they must be ignored.
  task automatic idle_in();
    bus.sample = 1'b0;
    bus.J      = 1'($urandom & 1);
    bus.K      = 1'($urandom & 1);
    bus.SE0    = 1'($urandom & 1);
  endtask

  // Pattern chars: K, J, S (SE0, J/K random), X (J&K), '.' (strobe, no qualifier).
  task automatic set_sym(input byte c);
    bus.sample = 1'b1;
    bus.J      = 1'b0;
    bus.K      = 1'b0;
    bus.SE0    = 1'b0;
    case (c)
      "K": bus.K = 1'b1;
      "J": bus.J = 1'b1;
      "S": begin
        bus.SE0 = 1'b1;
        bus.J   = 1'($urandom & 1);
        bus.K   = 1'($urandom & 1);
      end
      "X": begin
        bus.J = 1'b1;
        bus.K = 1'b1;
      end
      default: ;
    endcase
  endtask

  // Sequence-level reference: leading phase waits for the first K, then the
  // symbol at alternation position p must be K for even p and J for odd p.
  function automatic void predict(input bit hs, input string pat,
                                  output int kind, output int code,
                                  output int cnt, output int idx);
    int  i;
    int  strobes;
    int  maxl;
    byte c;
    kind = 0; code = 0; cnt = 0; idx = -1; strobes = 0;
    maxl = hs ? HS_LEN : FS_LEN;
    i = 0;
    while (i < pat.len() && pat[i] != "K") begin
      c = pat[i];
      if (c == "S") begin kind = 2; code = 1; idx = i; return; end
      if (c == "X") begin kind = 2; code = 0; idx = i; return; end
      if (c == "J" && !hs) begin kind = 2; code = 0; idx = i; return; end
      strobes++;
      if (strobes == TMO) begin kind = 2; code = 3; idx = i; return; end
      i++;
    end
    if (i >= pat.len()) return;
    cnt = 1;
    for (int j = i + 1; j < pat.len(); j++) begin
      c = pat[j];
      if (c == ".") continue;
      if (c == "S") begin kind = 2; code = 1; idx = j; return; end
      if (c == "X") begin kind = 2; code = 0; idx = j; return; end
      if (cnt >= maxl) begin kind = 2; code = 2; idx = j; return; end
      if (c == ((cnt % 2 == 1) ? "J" : "K")) begin
        cnt++;
      end else if (c == "K") begin
        cnt++;
        idx = j;
        if (hs ? (cnt >= HS_MIN && cnt <= HS_LEN) : (cnt == FS_LEN)) kind = 1;
        else begin kind = 2; code = 2; end
        return;
      end else begin
        kind = 2; code = 0; idx = j; return;
      end
    end
  endfunction

  // Arm, play pat (with random idle gaps), check result, then drop S_en.
  task automatic run_seq(input bit hs, input string pat, input int ek, input int ec,
                         input int ecnt, input int eidx, input string tag);
    bus.S_en    = 1'b1;
    bus.hs_mode = hs;
    idle_in();
    step();
    chk({tag, " arm_busy"}, int'(bus.busy), 1);
    chk({tag, " arm_code"}, int'(bus.err_code), 0);
    chk({tag, " arm_cnt"}, int'(bus.sym_cnt), 0);
    chk({tag, " arm_det"}, int'(bus.S_det), 0);
    chk({tag, " arm_err"}, int'(bus.S_err), 0);
    bus.hs_mode = ~hs;
    for (int i = 0; i < pat.len(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_in();
        step();
        chk({tag, " gap_det"}, int'(bus.S_det), 0);
        chk({tag, " gap_err"}, int'(bus.S_err), 0);
      end
      set_sym(pat[i]);
      step();
      chk({tag, " det"}, int'(bus.S_det), (i == eidx && ek == 1) ? 1 : 0);
      chk({tag, " err"}, int'(bus.S_err), (i == eidx && ek == 2) ? 1 : 0);
      if (i == eidx) break;
    end
    chk({tag, " code"}, int'(bus.err_code), (ek == 2) ? ec : 0);
    chk({tag, " cnt"}, int'(bus.sym_cnt), ecnt);
    chk({tag, " busy"}, int'(bus.busy), (ek == 0) ? 1 : 0);
    if (ek != 0) begin
      set_sym("K");
      step();
      chk({tag, " done_det"}, int'(bus.S_det), 0);
      chk({tag, " done_err"}, int'(bus.S_err), 0);
      chk({tag, " done_busy"}, int'(bus.busy), 0);
    end
    bus.S_en = 1'b0;
    idle_in();
    step();
    chk({tag, " off_det"}, int'(bus.S_det), 0);
    chk({tag, " off_err"}, int'(bus.S_err), 0);
    chk({tag, " off_busy"}, int'(bus.busy), 0);
    chk({tag, " off_cnt"}, int'(bus.sym_cnt), ecnt);
    chk({tag, " off_code"}, int'(bus.err_code), (ek == 2) ? ec : 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string jstr;
    string nstr;
    string hold;
    string pat;
    string sel;
    int    k, c, n, idx;
    bit    hs;

    RST         = 1'b0;
    bus.S_en    = 1'b0;
    bus.hs_mode = 1'b0;
    idle_in();
    repeat (3) step();
    chk("rst S_det", int'(bus.S_det), 0);
    chk("rst S_err", int'(bus.S_err), 0);
    chk("rst err_code", int'(bus.err_code), 0);
    chk("rst sym_cnt", int'(bus.sym_cnt), 0);
    chk("rst busy", int'(bus.busy), 0);
    RST = 1'b1;
    step();

    add(0, "KJKJKJKK", 1, 0, 8);
    add(1, {"JJ", alt(6), "KK"}, 1, 0, 14);
    add(0, "KJJ", 2, 0, 2);
    add(1, "KJKJKK", 2, 2, 6);
    add(0, "KJS", 2, 1, 2);
    add(0, "J", 2, 0, 0);
    add(1, "X", 2, 0, 0);
    add(1, "JJ.JS", 2, 1, 0);
    add(0, {alt(4), "K"}, 2, 2, 8);
    add(0, "KJKJKK", 2, 2, 6);
    add(0, "KK", 2, 2, 2);
    add(1, {alt(5), "KK"}, 1, 0, 12);
    add(1, {alt(4), "KK"}, 2, 2, 10);
    add(1, {alt(15), "KK"}, 1, 0, 32);
    add(1, {alt(16), "K"}, 2, 2, 32);
    add(0, "K.J.KJKJKK", 1, 0, 8);
    add(0, "KX", 2, 0, 1);
    add(0, "KJK", 0, 0, 3);
    add(1, "JJ", 0, 0, 0);
    foreach (tbl[i])
      run_seq(tbl[i].hs, tbl[i].pat, tbl[i].kind, tbl[i].code, tbl[i].cnt,
              (tbl[i].kind == 0) ? -1 : tbl[i].pat.len() - 1, "tbl");

    // Timeout boundaries: 64 waiting strobes time out; a K on strobe 64 does not.
    jstr = ""; nstr = "";
    for (int i = 0; i < TMO; i++) begin
      jstr = {jstr, "J"};
      nstr = {nstr, "."};
    end
    run_seq(1, jstr, 2, 3, 0, TMO - 1, "tmo_hs_j");
    run_seq(0, nstr, 2, 3, 0, TMO - 1, "tmo_fs_none");
    run_seq(1, {jstr.substr(0, TMO - 2), "KK"}, 2, 2, 2, TMO, "tmo_edge");

    // SE0 error, then S_en held high: DONE must absorb a full valid SYNC.
    bus.S_en = 1'b1; bus.hs_mode = 1'b0; idle_in(); step();
    set_sym("K"); step();
    set_sym("J"); step();
    set_sym("S"); step();
    chk("se0 S_err", int'(bus.S_err), 1);
    chk("se0 err_code", int'(bus.err_code), 1);
    chk("se0 sym_cnt", int'(bus.sym_cnt), 2);
    hold = {alt(3), "KK"};
    for (int i = 0; i < hold.len(); i++) begin
      set_sym(hold[i]); step();
      chk("hold S_det", int'(bus.S_det), 0);
      chk("hold S_err", int'(bus.S_err), 0);
    end
    chk("hold busy", int'(bus.busy), 0);
    chk("hold err_code", int'(bus.err_code), 1);
    bus.S_en = 1'b0; idle_in(); step();
    run_seq(0, "KJKJKJKK", 1, 0, 8, 7, "redet");

    // Asynchronous reset in the middle of ALT.
    bus.S_en = 1'b1; bus.hs_mode = 1'b1; idle_in(); step();
    set_sym("K"); step();
    set_sym("J"); step();
    set_sym("K"); step();
    chk("pre_rst busy", int'(bus.busy), 1);
    RST = 1'b0; bus.S_en = 1'b0; idle_in();
    #2;
    chk("mid_rst S_det", int'(bus.S_det), 0);
    chk("mid_rst S_err", int'(bus.S_err), 0);
    chk("mid_rst err_code", int'(bus.err_code), 0);
    chk("mid_rst sym_cnt", int'(bus.sym_cnt), 0);
    chk("mid_rst busy", int'(bus.busy), 0);
    step();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sym((i % 2 == 0) ? "J" : "K"); step();
      chk("post_rst S_det", int'(bus.S_det), 0);
      chk("post_rst S_err", int'(bus.S_err), 0);
      chk("post_rst busy", int'(bus.busy), 0);
    end
    // After reset the latched mode is FS: a leading J is an error.
    run_seq(0, "J", 2, 0, 0, 0, "post_rst_fs");

    // Randomized SYNC-like streams with occasional corruption.
    sel = "KJSX.";
    repeat (300) begin
      hs  = 1'($urandom & 1);
      pat = "";
      n   = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) pat = {pat, "J"};
      pat = {pat, "K"};
      n   = $urandom_range(0, hs ? 34 : 10);
      for (int i = 0; i < n; i++) pat = {pat, (i % 2 == 0) ? "J" : "K"};
      if ($urandom_range(0, 9) < 7) pat = {pat, "K"};
      for (int i = 0; i < pat.len(); i++)
        if ($urandom_range(0, 24) == 0) pat.putc(i, sel.getc($urandom_range(0, 4)));
      predict(hs, pat, k, c, n, idx);
      run_seq(hs, pat, k, c, n, idx, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
